// File: rtl/difftest_step_batcher.sv
// Batches per-cycle commit counts into checker requests, handshakes each batch
// and latches the first failing result along with the cycle it was issued at.
module difftest_step_batcher #(
  parameter int STEP_WIDTH      = 8,
  parameter int BATCH_WIDTH     = 16,
  parameter int BATCH_THRESHOLD = 64,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [STEP_WIDTH-1:0]  in_step,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BATCH_WIDTH-1:0] out_step,
  output logic [63:0]            out_cycle,
  input  logic                   result_valid,
  input  logic [31:0]            result_code,
  output logic                   fail,
  output logic [31:0]            fail_code,
  output logic [63:0]            fail_cycle,
  output logic                   overflow
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ACCUM, OFFER, WAIT_RESULT, FAILED} state_t;

  state_t                 state, state_next;
  logic [BATCH_WIDTH-1:0] acc;
  logic [TIMER_W-1:0]     timer;
  logic [63:0]            n_cycles;
  logic [BATCH_WIDTH:0]   acc_sum;
  logic                   emit;
  logic                   clamp;

  // One extra bit of headroom lets the outstanding-batch path detect the clamp.
  function automatic logic [BATCH_WIDTH-1:0] sat_acc(input logic [BATCH_WIDTH:0] v);
    if (v[BATCH_WIDTH]) return '1;
    return v[BATCH_WIDTH-1:0];
  endfunction

  assign acc_sum   = {1'b0, acc} + (BATCH_WIDTH+1)'(in_step);
  assign clamp     = acc_sum[BATCH_WIDTH];
  assign out_valid = (state == OFFER);

  always_comb begin
    emit       = 1'b0;
    state_next = state;
    case (state)
      ACCUM: begin
        emit = (acc_sum >= (BATCH_WIDTH+1)'(BATCH_THRESHOLD))
             | ((acc != '0) && (timer == TIMER_W'(TIMEOUT_CYCLES - 1)))
             | (flush && (acc_sum != '0));
        if (emit) state_next = OFFER;
      end
      OFFER: begin
        if (out_ready) state_next = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (result_valid) state_next = (result_code == 32'd0) ? ACCUM : FAILED;
      end
      default: state_next = FAILED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ACCUM;
      acc        <= '0;
      timer      <= '0;
      n_cycles   <= 64'd0;
      out_step   <= '0;
      out_cycle  <= 64'd0;
      fail       <= 1'b0;
      fail_code  <= 32'd0;
      fail_cycle <= 64'd0;
      overflow   <= 1'b0;
    end else begin
      state    <= state_next;
      n_cycles <= n_cycles + 64'd1;
      case (state)
        ACCUM: begin
          if (emit) begin
            out_step  <= acc_sum[BATCH_WIDTH-1:0];
            out_cycle <= n_cycles;
            acc       <= '0;
            timer     <= '0;
          end else begin
            acc   <= acc_sum[BATCH_WIDTH-1:0];
            timer <= (acc == '0) ? '0 : timer + 1'b1;
          end
        end
        OFFER, WAIT_RESULT: begin
          // Steps keep arriving while the checker is busy; hold them, never emit here.
          acc   <= sat_acc(acc_sum);
          timer <= '0;
          if (clamp) overflow <= 1'b1;
          if (state == WAIT_RESULT && result_valid && result_code != 32'd0) begin
            fail       <= 1'b1;
            fail_code  <= result_code;
            fail_cycle <= out_cycle;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Bench for difftest_step_batcher: vector table of steady step rates plus
// hand-written timeout, flush, saturation, failure and reset sequences.
module tb_difftest_step_batcher;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_step;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_step;
  logic [63:0] out_cycle;
  logic        result_valid;
  logic [31:0] result_code;
  logic        fail;
  logic [31:0] fail_code;
  logic [63:0] fail_cycle;
  logic        overflow;

  difftest_step_batcher dut (
    .clock(clock), .reset(reset), .in_step(in_step), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_step(out_step),
    .out_cycle(out_cycle), .result_valid(result_valid), .result_code(result_code),
    .fail(fail), .fail_code(fail_code), .fail_cycle(fail_cycle), .overflow(overflow)
  );

  always #5 clock = ~clock;

  logic [63:0] tb_cyc = 64'd0;
  always @(posedge clock) begin
    if (reset) tb_cyc <= 64'd0;
    else       tb_cyc <= tb_cyc + 64'd1;
  end

  typedef struct {
    logic [7:0]  step;
    logic [15:0] exp_step;
    int          exp_k;
  } vec_t;

  typedef struct {
    logic [15:0] step;
    logic [63:0] cyc;
  } exp_t;

  vec_t tbl[7];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   auto_resp = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic sb_push(input logic [15:0] s, input logic [63:0] c);
    exp_t e;
    e.step = s;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic check_batch();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected: got batch step %0d cycle %0d, expected none", out_step, out_cycle);
    end else begin
      e = sb.pop_front();
      chk("sb_step", 64'(out_step), 64'(e.step));
      chk("sb_cycle", out_cycle, e.cyc);
    end
  endtask

  // Inputs are set before calling; outputs are observed 1ns after the edge.
  task automatic tick();
    logic accepted;
    accepted = out_valid && out_ready;
    if (accepted) check_batch();
    @(posedge clock);
    #1;
    if (auto_resp) begin
      result_valid = accepted;
      result_code  = 32'd0;
    end
  endtask

  task automatic idle(input int n);
    in_step = 8'd0;
    flush   = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    k;
    bit    seen;
    bit    bad;
    logic [63:0] c0;

    tbl[0] = '{step: 8'd10,  exp_step: 16'd70,  exp_k: 7};
    tbl[1] = '{step: 8'd64,  exp_step: 16'd64,  exp_k: 1};
    tbl[2] = '{step: 8'd1,   exp_step: 16'd64,  exp_k: 64};
    tbl[3] = '{step: 8'd255, exp_step: 16'd255, exp_k: 1};
    tbl[4] = '{step: 8'd33,  exp_step: 16'd66,  exp_k: 2};
    tbl[5] = '{step: 8'd63,  exp_step: 16'd126, exp_k: 2};
    tbl[6] = '{step: 8'd21,  exp_step: 16'd84,  exp_k: 4};

    reset = 1'b1; in_step = 8'd0; flush = 1'b0; out_ready = 1'b1;
    result_valid = 1'b0; result_code = 32'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_step", 64'(out_step), 64'd0);
    chk("rst_out_cycle", out_cycle, 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_fail_code", 64'(fail_code), 64'd0);
    chk("rst_fail_cycle", fail_cycle, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // Steady step rates: latency in steps and batch value.
    for (int i = 0; i < 7; i++) begin
      k = 0;
      seen = 1'b0;
      while (!seen && k < 300) begin
        k++;
        in_step = tbl[i].step;
        if (k == tbl[i].exp_k) sb_push(tbl[i].exp_step, tb_cyc);
        tick();
        seen = out_valid;
      end
      in_step = 8'd0;
      chk("tbl_latency", 64'(k), 64'(tbl[i].exp_k));
      idle(4);
    end

    // Timeout emission of a lone partial batch.
    in_step = 8'd3;
    c0 = tb_cyc;
    sb_push(16'd3, c0 + 64'd256);
    tick();
    in_step = 8'd0;
    k = 0;
    while (!out_valid && k < 400) begin
      tick();
      k++;
    end
    chk("timeout_latency", tb_cyc - c0, 64'd257);
    idle(4);

    // Flush with pending steps, then flush with nothing pending.
    in_step = 8'd5;
    tick();
    in_step = 8'd0;
    flush = 1'b1;
    sb_push(16'd5, tb_cyc);
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd1);
    chk("flush_step", 64'(out_step), 64'd5);
    idle(4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_empty_valid", 64'(out_valid), 64'd0);
    tick();
    chk("flush_empty_valid2", 64'(out_valid), 64'd0);
    idle(2);

    // Stalled checker: accumulator saturates at 65535 exactly on the 258th step.
    out_ready = 1'b0;
    in_step = 8'd255;
    sb_push(16'd255, tb_cyc);
    tick();
    repeat (257) tick();
    chk("sat_no_overflow_yet", 64'(overflow), 64'd0);
    repeat (43) tick();
    in_step = 8'd0;
    chk("sat_overflow", 64'(overflow), 64'd1);
    chk("sat_valid_held", 64'(out_valid), 64'd1);
    chk("sat_step_held", 64'(out_step), 64'd255);
    out_ready = 1'b1;
    tick();
    tick();
    sb_push(16'd65535, tb_cyc);
    tick();
    chk("sat_batch_valid", 64'(out_valid), 64'd1);
    chk("sat_batch_step", 64'(out_step), 64'd65535);
    idle(4);
    chk("sat_overflow_sticky", 64'(overflow), 64'd1);

    // Reset while a batch awaits its result.
    auto_resp = 1'b0;
    in_step = 8'd64;
    sb_push(16'd64, tb_cyc);
    tick();
    in_step = 8'd0;
    tick();
    chk("pre_reset_overflow", 64'(overflow), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    auto_resp = 1'b1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_fail", 64'(fail), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_out_step", 64'(out_step), 64'd0);
    in_step = 8'd64;
    sb_push(16'd64, 64'd0);
    tick();
    in_step = 8'd0;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    idle(4);

    // Failing result for the batch issued at cycle 42.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(42);
    auto_resp = 1'b0;
    in_step = 8'd64;
    sb_push(16'd64, 64'd42);
    tick();
    in_step = 8'd0;
    tick();
    result_valid = 1'b1;
    result_code = 32'hff;
    tick();
    result_valid = 1'b0;
    result_code = 32'd0;
    chk("fail_flag", 64'(fail), 64'd1);
    chk("fail_code", 64'(fail_code), 64'hff);
    chk("fail_cycle", fail_cycle, 64'd42);
    in_step = 8'd255;
    result_valid = 1'b1;
    result_code = 32'd7;
    bad = 1'b0;
    tick();
    result_valid = 1'b0;
    result_code = 32'd0;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    in_step = 8'd0;
    chk("failed_no_valid", 64'(bad), 64'd0);
    chk("failed_code_kept", 64'(fail_code), 64'hff);
    chk("failed_flag_kept", 64'(fail), 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
